// File: rtl/mem_port_arbiter.sv
// Shares the single main-memory port between icache and dcache: one word
// transaction at a time, round-robin on contention, sticky no-answer watchdog.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [31:0] i_a,
    input  logic        i_access,
    output logic        i_ready,
    input  logic [31:0] d_a,
    input  logic [31:0] d_st_data,
    input  logic        d_access,
    input  logic        d_write,
    output logic        d_ready,
    output logic [31:0] mem_a,
    output logic [31:0] mem_st_data,
    output logic        mem_access,
    output logic        mem_write,
    input  logic        mem_ready,
    output logic        grant_i,
    output logic        grant_d,
    output logic        timeout_err
);

    // Handshake: a cache holds *_access until its *_ready pulses (one cycle,
    // equal to mem_ready while granted); dropping access early abandons it.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_e;

    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;
    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_e     state_q, state_d;
    logic       last_q, last_d;
    logic [7:0] wdog_q, wdog_d;
    logic       terr_q, terr_d;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
            last_q  <= LAST_I;
            wdog_q  <= 8'd0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
            terr_q  <= terr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        wdog_d  = wdog_q;
        case (state_q)
            IDLE: begin
                // Held at zero here so every SERVE entry starts a fresh count.
                wdog_d = 8'd0;
                if (i_access && d_access) begin
                    state_d = (last_q == LAST_I) ? SERVE_D : SERVE_I;
                end else if (i_access) begin
                    state_d = SERVE_I;
                end else if (d_access) begin
                    state_d = SERVE_D;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_ready) begin
                    state_d = IDLE;
                    last_d  = (state_q == SERVE_D) ? LAST_D : LAST_I;
                end else begin
                    if (wdog_q != TMO) begin
                        wdog_d = wdog_q + 8'd1;
                    end
                    if ((state_q == SERVE_I && !i_access) ||
                        (state_q == SERVE_D && !d_access)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        terr_d = terr_q | (wdog_d == TMO);
    end

    always_comb begin
        i_ready     = 1'b0;
        d_ready     = 1'b0;
        mem_a       = 32'd0;
        mem_st_data = 32'd0;
        mem_access  = 1'b0;
        mem_write   = 1'b0;
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        case (state_q)
            SERVE_I: begin
                mem_a      = i_a;
                mem_access = 1'b1;
                grant_i    = 1'b1;
                i_ready    = mem_ready;
            end
            SERVE_D: begin
                mem_a       = d_a;
                mem_st_data = d_st_data;
                mem_write   = d_write;
                mem_access  = 1'b1;
                grant_d     = 1'b1;
                d_ready     = mem_ready;
            end
            default: ;
        endcase
    end

    assign timeout_err = terr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected completions,
// a negedge monitor pops one per delivered ready and checks port invariants.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic [31:0] i_a = '0;
    logic        i_access = 1'b0;
    logic        i_ready;
    logic [31:0] d_a = '0;
    logic [31:0] d_st_data = '0;
    logic        d_access = 1'b0;
    logic        d_write = 1'b0;
    logic        d_ready;
    logic [31:0] mem_a;
    logic [31:0] mem_st_data;
    logic        mem_access;
    logic        mem_write;
    logic        mem_ready = 1'b0;
    logic        grant_i;
    logic        grant_d;
    logic        timeout_err;

    int n_vec  = 0;
    int n_fail = 0;

    // Completion record: {is_d, mem_a, mem_st_data, mem_write}
    logic [65:0] exp_q[$];

    mem_port_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .clrn(clrn),
        .i_a(i_a), .i_access(i_access), .i_ready(i_ready),
        .d_a(d_a), .d_st_data(d_st_data), .d_access(d_access),
        .d_write(d_write), .d_ready(d_ready),
        .mem_a(mem_a), .mem_st_data(mem_st_data), .mem_access(mem_access),
        .mem_write(mem_write), .mem_ready(mem_ready),
        .grant_i(grant_i), .grant_d(grant_d), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] all_outs();
        return {i_ready, d_ready, mem_a, mem_st_data, mem_access, mem_write,
                grant_i, grant_d, timeout_err};
    endfunction

    function automatic logic [65:0] rec_i(input logic [31:0] a);
        return {1'b0, a, 32'd0, 1'b0};
    endfunction

    function automatic logic [65:0] rec_d(input logic [31:0] a, input logic [31:0] wd,
                                          input logic wr);
        return {1'b1, a, wd, wr};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (clrn) begin
            chk("invariants",
                {71'd0, (grant_i && grant_d) || (i_ready && !grant_i) ||
                        (d_ready && !grant_d) || ((i_ready || d_ready) && !mem_ready)},
                72'd0);
            if (i_ready || d_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ready", {70'd0, i_ready, d_ready}, 72'd0);
                end else begin
                    chk("completion", {6'd0, d_ready, mem_a, mem_st_data, mem_write},
                        {6'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the first SERVE cycle; returns at the start of the IDLE bubble.
    task automatic serve_cur(input int waits);
        for (int k = 0; k < waits; k++) begin
            mem_ready = 1'b0;
            tick();
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        i_access = 1'b0;
        d_access = 1'b0;
        mem_ready = 1'b0;
        d_write = 1'b0;
        tick();
        tick();
        chk("reset_outputs", all_outs(), 72'd0);
        clrn = 1'b1;
        tick();
    endtask

    task automatic chk_idle(input string name);
        chk(name, {70'd0, mem_access, grant_i | grant_d}, 72'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();

        // 1: icache read, ready in 3rd SERVE cycle, then same-cache back-to-back
        i_a = 32'h0000_1000;
        i_access = 1'b1;
        exp_q.push_back(rec_i(32'h0000_1000));
        chk_idle("s1_request_cycle_idle");
        tick();
        chk("s1_serve", {mem_access, mem_write, grant_i, grant_d, mem_a, 36'd0},
            {4'b1010, 32'h0000_1000, 36'd0});
        serve_cur(2);
        chk_idle("s1_bubble");
        chk("s1_bubble_ready", {70'd0, i_ready, d_ready}, 72'd0);
        i_a = 32'h0000_1004;
        exp_q.push_back(rec_i(32'h0000_1004));
        tick();
        chk("s1_second_grant", {70'd0, grant_i, mem_access}, {70'd0, 2'b11});
        serve_cur(0);
        i_access = 1'b0;
        chk("s1_idle_outputs", all_outs(), 72'd0);

        // 2: dcache write
        tick();
        d_a = 32'h2000_0040;
        d_st_data = 32'hDEAD_BEEF;
        d_write = 1'b1;
        d_access = 1'b1;
        i_a = 32'hFFFF_FFFF;
        exp_q.push_back(rec_d(32'h2000_0040, 32'hDEAD_BEEF, 1'b1));
        tick();
        chk("s2_serve", {mem_access, mem_write, grant_i, grant_d, mem_a, mem_st_data, 4'd0},
            {4'b1101, 32'h2000_0040, 32'hDEAD_BEEF, 4'd0});
        serve_cur(1);
        d_access = 1'b0;
        chk_idle("s2_bubble");

        // last=D now, so a tie must go to icache
        i_a = 32'h0000_3000;
        d_a = 32'h0000_4000;
        d_write = 1'b0;
        i_access = 1'b1;
        d_access = 1'b1;
        exp_q.push_back(rec_i(32'h0000_3000));
        exp_q.push_back(rec_d(32'h0000_4000, 32'hDEAD_BEEF, 1'b0));
        tick();
        chk("s2_tie_after_d", {70'd0, grant_i, grant_d}, {70'd0, 2'b10});
        serve_cur(0);
        i_access = 1'b0;
        tick();
        chk("s2_d_follows", {70'd0, grant_i, grant_d}, {70'd0, 2'b01});
        serve_cur(0);
        d_access = 1'b0;

        // 3: simultaneous requests after reset -> D, bubble, I
        do_reset();
        i_a = 32'h0000_5000;
        d_a = 32'h0000_6000;
        d_st_data = 32'h1234_5678;
        d_write = 1'b1;
        i_access = 1'b1;
        d_access = 1'b1;
        exp_q.push_back(rec_d(32'h0000_6000, 32'h1234_5678, 1'b1));
        exp_q.push_back(rec_i(32'h0000_5000));
        tick();
        chk("s3_first_d", {70'd0, grant_i, grant_d}, {70'd0, 2'b01});
        serve_cur(1);
        d_access = 1'b0;
        chk_idle("s3_bubble");
        tick();
        chk("s3_then_i", {70'd0, grant_i, grant_d}, {70'd0, 2'b10});
        serve_cur(1);
        i_access = 1'b0;

        // 4: continuous contention, six transactions alternate D,I,...
        tick();
        i_a = 32'h0000_7000;
        d_a = 32'h0000_8000;
        d_st_data = 32'hCAFE_F00D;
        d_write = 1'b0;
        i_access = 1'b1;
        d_access = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) exp_q.push_back(rec_d(32'h0000_8000, 32'hCAFE_F00D, 1'b0));
            else            exp_q.push_back(rec_i(32'h0000_7000));
        end
        tick();
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("s4_grant_%0d", k), {70'd0, grant_i, grant_d},
                {70'd0, (k % 2 == 0) ? 2'b01 : 2'b10});
            serve_cur(0);
            chk_idle($sformatf("s4_bubble_%0d", k));
            if (k < 5) tick();
        end
        i_access = 1'b0;
        d_access = 1'b0;

        // 5: icache abandons, pending dcache takes the next arbitration
        tick();
        i_a = 32'h0000_9000;
        i_access = 1'b1;
        tick();
        chk("s5_grant_i", {70'd0, grant_i, grant_d}, {70'd0, 2'b10});
        d_a = 32'h0000_A000;
        d_st_data = 32'h0BAD_F00D;
        d_write = 1'b1;
        d_access = 1'b1;
        exp_q.push_back(rec_d(32'h0000_A000, 32'h0BAD_F00D, 1'b1));
        tick();
        i_access = 1'b0;
        tick();
        chk("s5_abandon_idle", all_outs(), 72'd0);
        tick();
        chk("s5_grant_d", {70'd0, grant_i, grant_d}, {70'd0, 2'b01});
        serve_cur(1);
        d_access = 1'b0;

        // 6: watchdog with TIMEOUT=4, then asynchronous reset mid-SERVE
        tick();
        d_a = 32'h0000_B000;
        d_st_data = 32'h0;
        d_write = 1'b0;
        d_access = 1'b1;
        exp_q.push_back(rec_d(32'h0000_B000, 32'h0, 1'b0));
        tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("s6_no_err_%0d", k), {71'd0, timeout_err}, 72'd0);
            tick();
        end
        chk("s6_err_set", {70'd0, timeout_err, grant_d}, {70'd0, 2'b11});
        serve_cur(0);
        d_access = 1'b0;
        chk("s6_err_sticky", {70'd0, timeout_err, mem_access}, {70'd0, 2'b10});
        tick();
        d_access = 1'b1;
        tick();
        chk("s6_serve_before_reset", {70'd0, mem_access, timeout_err}, {70'd0, 2'b11});
        #2;
        clrn = 1'b0;
        #1;
        chk("s6_async_reset", all_outs(), 72'd0);
        d_access = 1'b0;
        tick();
        clrn = 1'b1;
        tick();
        chk("s6_after_reset", all_outs(), 72'd0);

        tick();
        chk("queue_drained", 72'(exp_q.size()), 72'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates the single main-memory port between the instruction cache and the data cache of the cached/TLB pipeline CPU. One word transaction is granted at a time, with round-robin fairness on contention. The block drives the shared mem_a/mem_st_data/mem_access/mem_write lines and routes mem_ready back to the granted cache only. A watchdog flags a memory that never answers.

Parameters:
TIMEOUT, 255, cycles in a SERVE state without mem_ready before timeout_err sets (8-bit counter, 1..255).

Ports:
clk  in  1  clock; all state updates on rising edge
clrn  in  1  reset, asynchronous, active-low
i_a  in  32  icache miss address
i_access  in  1  icache requests a memory read
i_ready  out  1  memory ready, routed to icache
d_a  in  32  dcache address
d_st_data  in  32  dcache write data
d_access  in  1  dcache requests a memory access
d_write  in  1  dcache access is a write
d_ready  out  1  memory ready, routed to dcache
mem_a  out  32  main memory address
mem_st_data  out  32  main memory write data
mem_access  out  1  main memory access strobe
mem_write  out  1  main memory write enable
mem_ready  in  1  main memory has completed the current access
grant_i  out  1  icache currently owns the port
grant_d  out  1  dcache currently owns the port
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Clock is clk. Reset is clrn: asynchronous, active-low. While clrn=0, the block forces state IDLE, last=I, wdog=0, timeout_err=0, and sets every output to 0 immediately, including in the middle of a transaction.
- State encoding: IDLE, SERVE_I, SERVE_D. Registers: last (1 bit, the last completed winner) and wdog (8 bits).
- IDLE:
  - Only i_access=1: go to SERVE_I.
  - Only d_access=1: go to SERVE_D.
  - Both=1: grant the requester that is not last. After reset last=I, so D wins the first tie.
  - Neither: stay in IDLE.
- Grant is registered. A request first seen in an IDLE cycle is presented on mem_* in the next cycle. Minimum latency from request to mem_access is 1 cycle.
- SERVE_I drives: mem_a=i_a, mem_st_data=0, mem_write=0, mem_access=1, grant_i=1, i_ready=mem_ready.
- SERVE_D drives: mem_a=d_a, mem_st_data=d_st_data, mem_write=d_write, mem_access=1, grant_d=1, d_ready=mem_ready.
- IDLE drives: mem_a, mem_st_data, mem_access, mem_write, grants and readies all 0.
- The non-granted ready output is always 0. mem_* outputs are combinational from state and the granted requester's inputs.
- Completion: mem_ready=1 in SERVE_X goes to IDLE and sets last=X. There is always exactly one IDLE bubble between transactions, including back-to-back requests from the same cache.
- Abandon: the granted access drops to 0 before mem_ready. Go to IDLE next edge, last unchanged, no ready is delivered. A mem_ready in that same cycle counts as completion, not abandon.
- mem_ready in IDLE is ignored.
- Watchdog:
  - wdog clears on entry to SERVE_X and increments each SERVE cycle with mem_ready=0, saturating at TIMEOUT.
  - When wdog reaches TIMEOUT, timeout_err sets and stays 1 until clrn.
  - The transaction is not aborted; arbitration continues normally.
- Inputs of the non-granted requester never affect mem_* outputs.

Test Plan:
1. Reset, then i_access=1, i_a=0x0000_1000; memory returns mem_ready in the 3rd SERVE cycle -> mem_access=1, mem_a=0x1000, mem_write=0 from cycle 2. i_ready=1 only in the ready cycle, d_ready=0 throughout. Next cycle is IDLE with outputs 0.
2. d_access=1, d_write=1, d_a=0x2000_0040, d_st_data=0xDEAD_BEEF -> mem_a/mem_st_data/mem_write=1 match the dcache inputs. d_ready pulses with mem_ready, and last=D afterwards.
3. After reset, i_access and d_access both rise in the same cycle, with mem_ready 1 cycle after each grant -> order is D, bubble, I. grant_d and grant_i are never both 1.
4. Both requesters hold access continuously for 6 transactions -> grants alternate D,I,D,I,D,I with one IDLE cycle between each.
5. In SERVE_I, i_access drops before any mem_ready -> IDLE next edge, no i_ready pulse. A pending d_access is granted in the following arbitration cycle.
6. TIMEOUT=4, SERVE_D with mem_ready held 0 -> timeout_err=1 after 4 SERVE cycles. It stays 1 after a later completion. Asserting clrn mid-SERVE clears all outputs and timeout_err asynchronously.
